entity_mover: RTL and testbench

ENTITY_MOVER -- requirements
Module: entity_mover

---
 rtl/game_pkg.sv | 15 +
 rtl/entity_mover.sv | 105 ++++++++++
 tb/tb_entity_mover.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game constants and the entity FSM state encoding.
package game_pkg;

    localparam int SECTORS = 16;
    localparam int ANGLE_W = $clog2(SECTORS);

    localparam logic [8:0] START_DIST     = 9'd220;
    localparam logic [8:0] CENTER_DIST    = 9'd24;
    localparam logic [3:0] EXPLODE_FRAMES = 4'd8;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACTIVE  = 2'd1;
    localparam logic [1:0] S_EXPLODE = 2'd2;

endpackage

// File: rtl/entity_mover.sv
// Single entity moving radially toward the core: spawns, approaches per frame,
// explodes when shot in its sector, and reports core hits.
module entity_mover
    import game_pkg::*;
#(
    parameter logic [8:0] START_DIST     = game_pkg::START_DIST,
    parameter logic [8:0] CENTER_DIST    = game_pkg::CENTER_DIST,
    parameter logic [3:0] EXPLODE_FRAMES = game_pkg::EXPLODE_FRAMES
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               frame_tick,
    input  logic               spawn,
    input  logic [ANGLE_W-1:0] spawn_angle,
    input  logic [2:0]         speed,
    input  logic               pause,
    input  logic               shot,
    input  logic [ANGLE_W-1:0] shot_angle,
    output logic [8:0]         distance,
    output logic [ANGLE_W-1:0] angle,
    output logic               visible,
    output logic               exploding,
    output logic               destroyed,
    output logic               core_hit
);

    logic [1:0]        state;
    logic [3:0]        expl_cnt;
    logic [3:0]        expl_cnt_next;
    logic signed [9:0] dist_step;
    logic              reach_core;
    logic              hit;
    logic              move;

    // One extra bit keeps distance - speed from wrapping below zero.
    function automatic logic signed [9:0] step_dist(input logic [8:0] d, input logic [2:0] s);
        return signed'({1'b0, d}) - signed'({7'b0, s});
    endfunction

    assign dist_step     = step_dist(distance, speed);
    assign reach_core    = dist_step <= signed'({1'b0, CENTER_DIST});
    assign hit           = shot && (shot_angle == angle);
    assign move          = frame_tick && !pause;
    assign expl_cnt_next = expl_cnt + 4'd1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            distance  <= '0;
            angle     <= '0;
            visible   <= 1'b0;
            exploding <= 1'b0;
            destroyed <= 1'b0;
            core_hit  <= 1'b0;
            expl_cnt  <= '0;
        end else begin
            destroyed <= 1'b0;
            core_hit  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (spawn) begin
                        state    <= S_ACTIVE;
                        distance <= START_DIST;
                        angle    <= spawn_angle;
                        visible  <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    // A matching shot takes priority over motion, even on the core-reaching frame.
                    if (hit) begin
                        state     <= S_EXPLODE;
                        exploding <= 1'b1;
                        destroyed <= 1'b1;
                        expl_cnt  <= '0;
                    end else if (move) begin
                        if (reach_core) begin
                            distance <= CENTER_DIST;
                            core_hit <= 1'b1;
                            visible  <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            distance <= dist_step[8:0];
                        end
                    end
                end
                S_EXPLODE: begin
                    if (move) begin
                        expl_cnt <= expl_cnt_next;
                        if (expl_cnt_next == EXPLODE_FRAMES) begin
                            state     <= S_IDLE;
                            visible   <= 1'b0;
                            exploding <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    visible   <= 1'b0;
                    exploding <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_entity_mover.sv
// Self-checking bench for entity_mover: directed vector table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_entity_mover;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       spawn = 1'b0;
    logic [3:0] spawn_angle = '0;
    logic [2:0] speed = '0;
    logic       pause = 1'b0;
    logic       shot = 1'b0;
    logic [3:0] shot_angle = '0;
    logic [8:0] distance;
    logic [3:0] angle;
    logic       visible;
    logic       exploding;
    logic       destroyed;
    logic       core_hit;

    int tests = 0;
    int fails = 0;

    // Behavioural model: mode 0 = no entity, 1 = approaching, 2 = blowing up.
    int m_mode = 0;
    int m_dist = 0;
    int m_ang = 0;
    int m_frames = 0;
    int m_destroyed = 0;
    int m_core = 0;

    entity_mover dut (
        .CLK(clk), .RST_N(rst_n), .frame_tick(frame_tick), .spawn(spawn),
        .spawn_angle(spawn_angle), .speed(speed), .pause(pause), .shot(shot),
        .shot_angle(shot_angle), .distance(distance), .angle(angle),
        .visible(visible), .exploding(exploding), .destroyed(destroyed),
        .core_hit(core_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sp;
        logic [3:0] sa;
        logic [2:0] spd;
        logic       pa;
        logic       sh;
        logic [3:0] sha;
        logic       ft;
        int         e_dist;
        int         e_ang;
        int         e_vis;
        int         e_exp;
        int         e_des;
        int         e_core;
    } vec_t;

    vec_t vecs[9];

    task automatic cmp(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_dist = 0; m_ang = 0; m_frames = 0; m_destroyed = 0; m_core = 0;
    endtask

    task automatic model_step();
        m_destroyed = 0;
        m_core = 0;
        if (m_mode == 0) begin
            if (spawn) begin
                m_mode = 1; m_dist = 220; m_ang = int'(spawn_angle);
            end
        end else if (m_mode == 1) begin
            if (shot && int'(shot_angle) == m_ang) begin
                m_mode = 2; m_frames = 0; m_destroyed = 1;
            end else if (frame_tick && !pause) begin
                if (m_dist - int'(speed) <= 24) begin
                    m_dist = 24; m_core = 1; m_mode = 0;
                end else begin
                    m_dist = m_dist - int'(speed);
                end
            end
        end else begin
            if (frame_tick && !pause) begin
                m_frames++;
                if (m_frames == 8) m_mode = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        cmp({tag, ".distance"}, int'(distance), m_dist);
        cmp({tag, ".angle"}, int'(angle), m_ang);
        cmp({tag, ".visible"}, int'(visible), (m_mode != 0) ? 1 : 0);
        cmp({tag, ".exploding"}, int'(exploding), (m_mode == 2) ? 1 : 0);
        cmp({tag, ".destroyed"}, int'(destroyed), m_destroyed);
        cmp({tag, ".core_hit"}, int'(core_hit), m_core);
    endtask

    // Drive one cycle of inputs at the falling edge, sample 1ns after the rising edge.
    task automatic apply(input logic sp, input logic [3:0] sa, input logic [2:0] spd,
                         input logic pa, input logic sh, input logic [3:0] sha,
                         input logic ft, input string tag);
        @(negedge clk);
        spawn = sp; spawn_angle = sa; speed = spd; pause = pa;
        shot = sh; shot_angle = sha; frame_tick = ft;
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic ticks(input int n, input logic [2:0] spd, input logic pa, input string tag);
        for (int i = 0; i < n; i++) apply(1'b0, 4'd0, spd, pa, 1'b0, 4'd0, 1'b1, tag);
    endtask

    task automatic idle_cycle(input string tag);
        apply(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, tag);
    endtask

    initial begin
        //          sp    sa     spd   pa    sh    sha    ft    dist ang vis exp des core
        vecs[0] = '{1'b1, 4'd5,  3'd3, 1'b0, 1'b0, 4'd0,  1'b0, 220, 5, 1, 0, 0, 0};
        vecs[1] = '{1'b1, 4'd9,  3'd3, 1'b0, 1'b0, 4'd0,  1'b0, 220, 5, 1, 0, 0, 0};
        vecs[2] = '{1'b0, 4'd0,  3'd3, 1'b0, 1'b0, 4'd0,  1'b1, 217, 5, 1, 0, 0, 0};
        vecs[3] = '{1'b0, 4'd0,  3'd3, 1'b0, 1'b1, 4'd6,  1'b0, 217, 5, 1, 0, 0, 0};
        vecs[4] = '{1'b0, 4'd0,  3'd3, 1'b1, 1'b0, 4'd0,  1'b1, 217, 5, 1, 0, 0, 0};
        vecs[5] = '{1'b0, 4'd0,  3'd7, 1'b0, 1'b0, 4'd0,  1'b1, 210, 5, 1, 0, 0, 0};
        vecs[6] = '{1'b0, 4'd0,  3'd7, 1'b1, 1'b1, 4'd5,  1'b1, 210, 5, 1, 1, 1, 0};
        vecs[7] = '{1'b0, 4'd0,  3'd0, 1'b0, 1'b0, 4'd0,  1'b0, 210, 5, 1, 1, 0, 0};
        vecs[8] = '{1'b1, 4'd2,  3'd0, 1'b0, 1'b1, 4'd5,  1'b0, 210, 5, 1, 1, 0, 0};

        // Reset state
        model_reset();
        #12;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table: spawn, ignored respawn, motion, miss, pause, hit
        for (int i = 0; i < 9; i++) begin
            apply(vecs[i].sp, vecs[i].sa, vecs[i].spd, vecs[i].pa, vecs[i].sh,
                  vecs[i].sha, vecs[i].ft, $sformatf("vec%0d", i));
            cmp($sformatf("vec%0d.tbl_distance", i), int'(distance), vecs[i].e_dist);
            cmp($sformatf("vec%0d.tbl_angle", i), int'(angle), vecs[i].e_ang);
            cmp($sformatf("vec%0d.tbl_visible", i), int'(visible), vecs[i].e_vis);
            cmp($sformatf("vec%0d.tbl_exploding", i), int'(exploding), vecs[i].e_exp);
            cmp($sformatf("vec%0d.tbl_destroyed", i), int'(destroyed), vecs[i].e_des);
            cmp($sformatf("vec%0d.tbl_core_hit", i), int'(core_hit), vecs[i].e_core);
        end

        // Explosion timer: paused ticks do not count, 8th live tick ends it
        ticks(3, 3'd0, 1'b0, "expl_a");
        ticks(2, 3'd0, 1'b1, "expl_pause");
        ticks(4, 3'd0, 1'b0, "expl_b");
        cmp("expl_7_visible", int'(visible), 1);
        cmp("expl_7_distance", int'(distance), 210);
        ticks(1, 3'd0, 1'b0, "expl_end");
        cmp("expl_8_visible", int'(visible), 0);
        cmp("expl_8_exploding", int'(exploding), 0);

        // Spawn and ten ticks at speed 3
        apply(1'b1, 4'd5, 3'd3, 1'b0, 1'b0, 4'd0, 1'b0, "spawn2");
        ticks(10, 3'd3, 1'b0, "move10");
        cmp("move10_distance", int'(distance), 190);
        apply(1'b0, 4'd0, 3'd3, 1'b0, 1'b1, 4'd6, 1'b0, "miss");
        ticks(5, 3'd7, 1'b1, "paused5");
        cmp("paused5_distance", int'(distance), 190);

        // Core reach: 190 -> 29 -> 26, then speed 4 clamps to 24
        ticks(23, 3'd7, 1'b0, "approach");
        ticks(1, 3'd3, 1'b0, "approach26");
        cmp("at26_distance", int'(distance), 26);
        ticks(1, 3'd4, 1'b0, "core");
        cmp("core_distance", int'(distance), 24);
        cmp("core_pulse", int'(core_hit), 1);
        cmp("core_visible", int'(visible), 0);
        idle_cycle("core_after");
        cmp("core_pulse_end", int'(core_hit), 0);

        // Collision: matching shot on the core-reaching tick
        apply(1'b1, 4'd3, 3'd7, 1'b0, 1'b0, 4'd0, 1'b0, "spawn3");
        ticks(27, 3'd7, 1'b0, "approach3");
        ticks(1, 3'd5, 1'b0, "approach3_26");
        apply(1'b0, 4'd0, 3'd4, 1'b0, 1'b1, 4'd3, 1'b1, "collide");
        cmp("collide_destroyed", int'(destroyed), 1);
        cmp("collide_core_hit", int'(core_hit), 0);
        cmp("collide_exploding", int'(exploding), 1);
        cmp("collide_distance", int'(distance), 26);

        // Asynchronous reset in the middle of an explosion
        ticks(2, 3'd0, 1'b0, "collide_expl");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 4'd12, 3'd2, 1'b0, 1'b0, 4'd0, 1'b0, "first_spawn");
        cmp("first_spawn_visible", int'(visible), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic       r_sp, r_pa, r_sh, r_ft;
            logic [3:0] r_sa, r_sha;
            logic [2:0] r_spd;
            r_sp  = ($urandom_range(0, 9) == 0);
            r_sa  = 4'($urandom_range(0, 15));
            r_spd = 3'($urandom_range(0, 7));
            r_pa  = ($urandom_range(0, 6) == 0);
            r_sh  = ($urandom_range(0, 19) == 0);
            r_sha = ($urandom_range(0, 1) == 0) ? 4'(m_ang) : 4'($urandom_range(0, 15));
            r_ft  = ($urandom_range(0, 2) == 0);
            apply(r_sp, r_sa, r_spd, r_pa, r_sh, r_sha, r_ft, "rand");
            cmp("rand_pulse_exclusive", int'(destroyed && core_hit), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
